// File: rtl/joystick_port.sv
// joystick_port: debounces two joysticks and maps them onto the Kempston port or Sinclair half-rows.
// Optional autofire on F1 is compiled in with `define JOYSTICK_AUTOFIRE_EN.
`default_nettype none

module joystick_port #(
  parameter int DEBOUNCE = 3,
  parameter int AF_HOLD  = 16,
  parameter int AF_RATE  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [7:0]  joy1,
  input  logic [7:0]  joy2,
  input  logic [1:0]  mode,
  input  logic [15:0] a,
  input  logic        iorq,
  input  logic        rd,
  output logic [7:0]  kempD,
  output logic        kempOe,
  output logic [4:0]  sincRow
);

  localparam logic [2:0] DB_LAST = 3'(DEBOUNCE - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic [11:0] raw;
  logic [11:0] filt;
  logic [2:0]  cnt [12];
  logic [1:0]  eff_f1;
  logic [5:0]  j1;
  logic [5:0]  j2;
  logic [5:0]  kemp_src;
  logic        kemp_on;
  logic        sinc1_on;
  logic        sinc2_on;
  logic        kreq;
  logic [4:0]  sinc_nx;
  state_t      state;
  state_t      state_nx;

  assign raw = {joy2[5:0], joy1[5:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt <= '0;
      for (int i = 0; i < 12; i++) cnt[i] <= '0;
    end else if (ce) begin
      for (int i = 0; i < 12; i++) begin
        if (raw[i] != filt[i]) begin
          if (cnt[i] == DB_LAST) begin
            filt[i] <= raw[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 3'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

`ifdef JOYSTICK_AUTOFIRE_EN
  localparam int HW = $clog2(AF_HOLD + 1);
  localparam int RW = $clog2(AF_RATE + 1);

  for (genvar j = 0; j < 2; j++) begin : g_af
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rate_cnt;
    logic          tog;
    logic          f1;

    assign f1 = filt[6*j+4];

    // Release clears on any clock, not just on ce, so fire drops at once.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        hold_cnt <= '0;
        rate_cnt <= '0;
        tog      <= 1'b0;
      end else if (!f1) begin
        hold_cnt <= '0;
        rate_cnt <= '0;
        tog      <= 1'b0;
      end else if (ce) begin
        if (hold_cnt != HW'(AF_HOLD)) begin
          hold_cnt <= hold_cnt + 1'b1;
        end else if (rate_cnt == RW'(AF_RATE - 1)) begin
          rate_cnt <= '0;
          tog      <= ~tog;
        end else begin
          rate_cnt <= rate_cnt + 1'b1;
        end
      end
    end

    assign eff_f1[j] = f1 & ((hold_cnt != HW'(AF_HOLD)) | tog);
  end
`else
  assign eff_f1 = {filt[10], filt[4]};
`endif

  assign j1 = {filt[5],  eff_f1[0], filt[3:0]};
  assign j2 = {filt[11], eff_f1[1], filt[9:6]};

  assign kemp_on  = (mode != 2'b10);
  assign sinc1_on = (mode == 2'b01) || (mode == 2'b10);
  assign sinc2_on = (mode == 2'b00) || (mode == 2'b10);
  assign kemp_src = (mode == 2'b01) ? j2 : j1;
  assign kreq     = !iorq && !rd && (a[7:0] == 8'h1F) && kemp_on;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (kreq)  state_nx = S_HOLD;
      S_HOLD:  if (!kreq) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      kempD <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && kreq) kempD <= {2'b00, kemp_src};
    end
  end

  assign kempOe = (state == S_HOLD);

  always_comb begin
    sinc_nx = 5'h1F;
    if (!a[12] && sinc1_on) sinc_nx = sinc_nx & ~{j1[1], j1[0], j1[2], j1[3], j1[4]};
    if (!a[11] && sinc2_on) sinc_nx = sinc_nx & ~{j2[4], j2[3], j2[2], j2[0], j2[1]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sincRow <= 5'h1F;
    else        sincRow <= sinc_nx;
  end

endmodule

`default_nettype wire

// File: tb/tb_joystick_port.sv
// tb_joystick_port: directed vector table plus randomized traffic against a behavioural model.
`default_nettype none

module tb_joystick_port;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic [7:0]  joy1 = '0;
  logic [7:0]  joy2 = '0;
  logic [1:0]  mode = '0;
  logic [15:0] a = '0;
  logic        iorq = 1'b1;
  logic        rd = 1'b1;
  logic [7:0]  kempD;
  logic        kempOe;
  logic [4:0]  sincRow;

  int tests = 0;
  int fails = 0;

  joystick_port #(.DEBOUNCE(3), .AF_HOLD(16), .AF_RATE(4)) dut (
    .clock(clock), .reset(reset), .ce(ce), .joy1(joy1), .joy2(joy2), .mode(mode),
    .a(a), .iorq(iorq), .rd(rd), .kempD(kempD), .kempOe(kempOe), .sincRow(sincRow)
  );

  always #5 clock = ~clock;

  // Behavioural model: per-bit run length of disagreeing samples, and the read-latch view.
  int       run [12];
  bit       fb [12];
  bit       m_hold;
  bit [7:0] m_kd;
  bit [4:0] m_sinc;
  // Sinclair column bit -> joystick bit (R=0 L=1 D=2 U=3 F1=4)
  int s1_key [5] = '{4, 3, 2, 0, 1};
  int s2_key [5] = '{1, 0, 2, 3, 4};

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin run[i] = 0; fb[i] = 0; end
    m_hold = 0; m_kd = 8'h00; m_sinc = 5'h1F;
  endtask

  task automatic model_edge();
    bit       kreq;
    bit [5:0] src;
    bit [11:0] rawv;
    int        base;
    kreq = !iorq && !rd && a[7:0] == 8'h1F && mode != 2'd2;
    base = (mode == 2'd1) ? 6 : 0;
    for (int i = 0; i < 6; i++) src[i] = fb[base + i];
    if (!m_hold && kreq) m_kd = {2'b00, src};
    m_hold = kreq;
    m_sinc = 5'h1F;
    for (int k = 0; k < 5; k++) begin
      if (!a[12] && (mode == 2'd1 || mode == 2'd2) && fb[s1_key[k]])     m_sinc[k] = 1'b0;
      if (!a[11] && (mode == 2'd0 || mode == 2'd2) && fb[6 + s2_key[k]]) m_sinc[k] = 1'b0;
    end
    rawv = {joy2[5:0], joy1[5:0]};
    if (ce) begin
      for (int i = 0; i < 12; i++) begin
        if (rawv[i] != fb[i]) begin
          run[i]++;
          if (run[i] == 3) begin fb[i] = rawv[i]; run[i] = 0; end
        end else begin
          run[i] = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " oe"},   {7'd0, kempOe}, {7'd0, m_hold});
    check({tag, " kd"},   kempD, m_kd);
    check({tag, " sinc"}, {3'd0, sincRow}, {3'd0, m_sinc});
  endtask

  task automatic step(input logic c, input logic [7:0] j1, input logic [7:0] j2, input logic [1:0] m,
                      input logic [15:0] ad, input logic io, input logic r);
    @(negedge clock);
    ce = c; joy1 = j1; joy2 = j2; mode = m; a = ad; iorq = io; rd = r;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        c;
    logic [7:0]  j1;
    logic [7:0]  j2;
    logic [1:0]  m;
    logic [15:0] ad;
    logic        io;
    logic        r;
    logic        oe;
    logic [7:0]  kd;
    logic [4:0]  sinc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, input logic [7:0] j1, input logic [7:0] j2, input logic [1:0] m,
                     input logic [15:0] ad, input logic io, input logic r,
                     input logic oe, input logic [7:0] kd, input logic [4:0] sinc);
    vec_t v;
    v.c = c; v.j1 = j1; v.j2 = j2; v.m = m; v.ad = ad; v.io = io; v.r = r;
    v.oe = oe; v.kd = kd; v.sinc = sinc;
    tbl.push_back(v);
  endtask

  initial begin
    // glitch of two samples must not pass; three samples must
    add(1, 8'h01, 8'h00, 2'd0, 16'h0000, 1, 1, 0, 8'h00, 5'h1F);
    add(1, 8'h01, 8'h00, 2'd0, 16'h0000, 1, 1, 0, 8'h00, 5'h1F);
    add(1, 8'h00, 8'h00, 2'd0, 16'h0000, 1, 1, 0, 8'h00, 5'h1F);
    add(0, 8'h00, 8'h00, 2'd0, 16'h001F, 0, 0, 1, 8'h00, 5'h1F);
    add(0, 8'h00, 8'h00, 2'd0, 16'h001F, 1, 1, 0, 8'h00, 5'h1F);
    add(1, 8'h01, 8'h00, 2'd0, 16'h0000, 1, 1, 0, 8'h00, 5'h1F);
    add(1, 8'h01, 8'h00, 2'd0, 16'h0000, 1, 1, 0, 8'h00, 5'h1F);
    add(1, 8'h01, 8'h00, 2'd0, 16'h0000, 1, 1, 0, 8'h00, 5'h1F);
    add(0, 8'h01, 8'h00, 2'd0, 16'h001F, 0, 0, 1, 8'h01, 5'h1F);
    add(0, 8'h01, 8'h00, 2'd0, 16'h001F, 1, 1, 0, 8'h01, 5'h1F);
    // Kempston read with joy1 changing mid-read
    add(1, 8'h18, 8'h00, 2'd0, 16'h0000, 1, 1, 0, 8'h01, 5'h1F);
    add(1, 8'h18, 8'h00, 2'd0, 16'h0000, 1, 1, 0, 8'h01, 5'h1F);
    add(1, 8'h18, 8'h00, 2'd0, 16'h0000, 1, 1, 0, 8'h01, 5'h1F);
    add(0, 8'h18, 8'h00, 2'd0, 16'h001F, 0, 0, 1, 8'h18, 5'h1F);
    add(1, 8'h00, 8'h00, 2'd0, 16'h001F, 0, 0, 1, 8'h18, 5'h1F);
    add(1, 8'h00, 8'h00, 2'd0, 16'h001F, 0, 0, 1, 8'h18, 5'h1F);
    add(1, 8'h00, 8'h00, 2'd0, 16'h001F, 0, 0, 1, 8'h18, 5'h1F);
    add(0, 8'h00, 8'h00, 2'd0, 16'h001F, 1, 1, 0, 8'h18, 5'h1F);
    add(0, 8'h00, 8'h00, 2'd0, 16'h001F, 0, 0, 1, 8'h00, 5'h1F);
    add(0, 8'h00, 8'h00, 2'd0, 16'h001F, 1, 1, 0, 8'h00, 5'h1F);
    // Sinclair 2 in mode 00
    add(1, 8'h00, 8'h11, 2'd0, 16'hFEFE, 1, 1, 0, 8'h00, 5'h1F);
    add(1, 8'h00, 8'h11, 2'd0, 16'hFEFE, 1, 1, 0, 8'h00, 5'h1F);
    add(1, 8'h00, 8'h11, 2'd0, 16'hFEFE, 1, 1, 0, 8'h00, 5'h1F);
    add(0, 8'h00, 8'h11, 2'd0, 16'hF7FE, 1, 1, 0, 8'h00, 5'b01101);
    add(0, 8'h00, 8'h11, 2'd0, 16'hFEFE, 1, 1, 0, 8'h00, 5'h1F);
    // both Sinclair rows
    add(1, 8'h08, 8'h02, 2'd2, 16'hFEFE, 1, 1, 0, 8'h00, 5'h1F);
    add(1, 8'h08, 8'h02, 2'd2, 16'hFEFE, 1, 1, 0, 8'h00, 5'h1F);
    add(1, 8'h08, 8'h02, 2'd2, 16'hFEFE, 1, 1, 0, 8'h00, 5'h1F);
    add(0, 8'h08, 8'h02, 2'd2, 16'hE7FE, 1, 1, 0, 8'h00, 5'b11100);
    // mode 11: Kempston from joy1, joy2 disabled
    add(1, 8'h01, 8'h1F, 2'd3, 16'h0000, 1, 1, 0, 8'h00, 5'h1F);
    add(1, 8'h01, 8'h1F, 2'd3, 16'h0000, 1, 1, 0, 8'h00, 5'h1F);
    add(1, 8'h01, 8'h1F, 2'd3, 16'h0000, 1, 1, 0, 8'h00, 5'h1F);
    add(0, 8'h01, 8'h1F, 2'd3, 16'h001F, 0, 0, 1, 8'h01, 5'h1F);
    add(0, 8'h01, 8'h1F, 2'd3, 16'hF7FE, 1, 1, 0, 8'h01, 5'h1F);
    // mode 10 has no Kempston; mode 01 reads joy2, opposite directions pass
    add(0, 8'h01, 8'h1F, 2'd2, 16'h001F, 0, 0, 0, 8'h01, 5'b00000);
    add(0, 8'h01, 8'h1F, 2'd1, 16'h001F, 0, 0, 1, 8'h1F, 5'b10111);
    add(0, 8'h01, 8'h1F, 2'd1, 16'h001F, 1, 1, 0, 8'h1F, 5'b10111);

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset oe", {7'd0, kempOe}, 8'h00);
    check("reset kd", kempD, 8'h00);
    check("reset sinc", {3'd0, sincRow}, 8'h1F);
    @(negedge clock) reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c, tbl[i].j1, tbl[i].j2, tbl[i].m, tbl[i].ad, tbl[i].io, tbl[i].r);
      check($sformatf("vec%0d oe", i), {7'd0, kempOe}, {7'd0, tbl[i].oe});
      check($sformatf("vec%0d kd", i), kempD, tbl[i].kd);
      check($sformatf("vec%0d sinc", i), {3'd0, sincRow}, {3'd0, tbl[i].sinc});
      check_model($sformatf("vec%0d model", i));
    end

    // asynchronous reset in the middle of a read
    step(0, 8'h01, 8'h1F, 2'd1, 16'h001F, 0, 0);
    check("midread oe before", {7'd0, kempOe}, 8'h01);
    #2 reset = 1'b0;
    #1;
    check("async rst oe", {7'd0, kempOe}, 8'h00);
    check("async rst kd", kempD, 8'h00);
    check("async rst sinc", {3'd0, sincRow}, 8'h1F);
    model_reset();
    @(negedge clock) reset = 1'b1;
    // first read after reset sees only filtered (zero) data
    step(0, 8'h3F, 8'h3F, 2'd0, 16'h001F, 0, 0);
    check("post rst kd", kempD, 8'h00);
    check("post rst oe", {7'd0, kempOe}, 8'h01);
    check_model("post rst");

    for (int n = 0; n < 800; n++) begin
      logic [15:0] ad;
      logic [7:0]  nj1, nj2;
      logic [1:0]  nm;
      nj1 = ($urandom_range(0, 5) == 0) ? 8'($urandom) : joy1;
      nj2 = ($urandom_range(0, 5) == 0) ? 8'($urandom) : joy2;
      nm  = ($urandom_range(0, 15) == 0) ? 2'($urandom) : mode;
      case ($urandom_range(0, 4))
        0: ad = 16'h001F;
        1: ad = 16'hF7FE;
        2: ad = 16'hEFFE;
        3: ad = 16'hE7FE;
        default: ad = 16'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, nj1, nj2, nm, ad,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      check_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
